aes_encrypt_iter: RTL and testbench



---
 rtl/aes_encrypt_iter.sv | 211 +++++++++++++++++++++
 tb/tb_aes_encrypt_iter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/aes_encrypt_iter.sv
// Iterative AES encryptor: one cipher round per clock behind a start/busy/done handshake.
// Define AES_ENC_ROUND_TAP_EN to expose round_state/round_idx for round-by-round debug.
module aes_encrypt_iter #(
   parameter int Nk = 4,
   parameter int Nr = 10
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [127:0]      in,
   input  logic [32*Nk-1:0]  key,
   output logic [127:0]      out,
   output logic              busy,
   output logic              done
`ifdef AES_ENC_ROUND_TAP_EN
   ,
   output logic [127:0]      round_state,
   output logic [3:0]        round_idx
`endif
);

   localparam int          NW       = 4 * (Nr + 1);
   localparam int          SCHED_W  = 128 * (Nr + 1);
   localparam logic [3:0]  LAST_RND = 4'(Nr - 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_INIT  = 2'd1;
   localparam logic [1:0] S_ROUND = 2'd2;
   localparam logic [1:0] S_FINAL = 2'd3;

   if (Nr != Nk + 6) begin : g_bad_cfg
      $error("aes_encrypt_iter: Nr must equal Nk+6");
   end

   function automatic logic [7:0] xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] aa;
      p  = 8'h00;
      aa = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ aa;
         aa = xt(aa);
      end
      return p;
   endfunction

   // S-box built from the field inverse (x^254) followed by the affine map.
   function automatic logic [7:0] sbox(input logic [7:0] x);
      logic [7:0] inv;
      logic [7:0] sq;
      inv = 8'h01;
      sq  = x;
      for (int i = 1; i < 8; i++) begin
         sq  = gf_mul(sq, sq);
         inv = gf_mul(inv, sq);
      end
      return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
             {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
   endfunction

   // Byte r+4c of the state sits at bits [127-8*(r+4c) -: 8].
   function automatic logic [127:0] sub_shift(input logic [127:0] s);
      logic [127:0] o;
      o = '0;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            o[127-8*(4*c+r) -: 8] = sbox(s[127-8*(4*((c+r)%4)+r) -: 8]);
      return o;
   endfunction

   function automatic logic [127:0] mix_columns(input logic [127:0] s);
      logic [127:0] o;
      logic [7:0]   a0, a1, a2, a3;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         a0 = s[127-32*c -: 8];
         a1 = s[119-32*c -: 8];
         a2 = s[111-32*c -: 8];
         a3 = s[103-32*c -: 8];
         o[127-32*c -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
         o[119-32*c -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
         o[111-32*c -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
         o[103-32*c -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
      end
      return o;
   endfunction

   // Full schedule, round key 0 in the top 128 bits.
   function automatic logic [SCHED_W-1:0] expand_key(input logic [32*Nk-1:0] k);
      logic [31:0]        w [0:NW-1];
      logic [31:0]        t;
      logic [7:0]         rc;
      logic [SCHED_W-1:0] o;
      rc = 8'h01;
      o  = '0;
      for (int i = 0; i < Nk; i++) begin
         w[i] = k[32*Nk-1-32*i -: 32];
         o[SCHED_W-1-32*i -: 32] = w[i];
      end
      for (int i = Nk; i < NW; i++) begin
         t = w[i-1];
         if (i % Nk == 0) begin
            t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
            rc = xt(rc);
         end else if (Nk > 6 && i % Nk == 4) begin
            t = sub_word(t);
         end
         w[i] = w[i-Nk] ^ t;
         o[SCHED_W-1-32*i -: 32] = w[i];
      end
      return o;
   endfunction

   logic [1:0]          r_state;
   logic [3:0]          r_rnd;
   logic [127:0]        r_pt;
   logic [32*Nk-1:0]    r_key;
   logic [127:0]        r_st;
   logic [127:0]        r_out;
   logic                r_busy;
   logic                r_done;

   logic [SCHED_W-1:0]  w_sched;
   logic [127:0]        w_rk_cur;
   logic [127:0]        w_sr;
   logic [127:0]        w_round;
   logic [127:0]        w_final;
   logic [127:0]        w_init;

   assign w_sched  = expand_key(r_key);
   assign w_rk_cur = w_sched[SCHED_W-1-128*r_rnd -: 128];
   assign w_sr     = sub_shift(r_st);
   assign w_round  = mix_columns(w_sr) ^ w_rk_cur;
   assign w_final  = w_sr ^ w_sched[127:0];
   assign w_init   = r_pt ^ w_sched[SCHED_W-1 -: 128];

`ifdef AES_ENC_ROUND_TAP_EN
   logic [127:0] r_round_state;
   logic [3:0]   r_round_idx;
   assign round_state = r_round_state;
   assign round_idx   = r_round_idx;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_round_state <= '0;
         r_round_idx   <= '0;
      end else begin
         case (r_state)
            S_INIT:  begin r_round_state <= w_init;  r_round_idx <= 4'd0;    end
            S_ROUND: begin r_round_state <= w_round; r_round_idx <= r_rnd;   end
            S_FINAL: begin r_round_state <= w_final; r_round_idx <= 4'(Nr);  end
            default: ;
         endcase
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_rnd   <= '0;
         r_pt    <= '0;
         r_key   <= '0;
         r_st    <= '0;
         r_out   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: if (start) begin
               r_pt    <= in;
               r_key   <= key;
               r_busy  <= 1'b1;
               r_state <= S_INIT;
            end
            S_INIT: begin
               r_st    <= w_init;
               r_rnd   <= 4'd1;
               r_state <= S_ROUND;
            end
            S_ROUND: begin
               r_st  <= w_round;
               r_rnd <= r_rnd + 4'd1;
               if (r_rnd == LAST_RND) r_state <= S_FINAL;
            end
            S_FINAL: begin
               r_out   <= w_final;
               r_done  <= 1'b1;
               r_busy  <= 1'b0;
               r_rnd   <= '0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign out  = r_out;
   assign busy = r_busy;
   assign done = r_done;

endmodule

// File: tb/tb_aes_encrypt_iter.sv
// Directed bench for aes_encrypt_iter using the FIPS-197 Appendix B/C vectors.
module tb_aes_encrypt_iter;

   localparam logic [127:0] PT_C   = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] K128_C = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [191:0] K192_C = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
   localparam logic [255:0] K256_C = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
   localparam logic [127:0] CT128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] CT192  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
   localparam logic [127:0] CT256  = 128'h8ea2b7ca516745bfeafc49904b496089;
   localparam logic [127:0] K_B    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] R1_B   = 128'ha49c7ff2689f352b6b5bea43026a5049;

   logic         clk = 1'b0;
   logic         reset;
   logic         start128, start192, start256;
   logic [127:0] din;
   logic [127:0] key128;
   logic [191:0] key192;
   logic [255:0] key256;
   logic [127:0] out128, out192, out256;
   logic         busy128, busy192, busy256;
   logic         done128, done192, done256;
`ifdef AES_ENC_ROUND_TAP_EN
   logic [127:0] rs128, rs192, rs256;
   logic [3:0]   ri128, ri192, ri256;
`endif

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   aes_encrypt_iter #(.Nk(4), .Nr(10)) dut128 (
      .clk(clk), .reset(reset), .start(start128), .in(din), .key(key128),
      .out(out128), .busy(busy128), .done(done128)
`ifdef AES_ENC_ROUND_TAP_EN
      , .round_state(rs128), .round_idx(ri128)
`endif
   );

   aes_encrypt_iter #(.Nk(6), .Nr(12)) dut192 (
      .clk(clk), .reset(reset), .start(start192), .in(din), .key(key192),
      .out(out192), .busy(busy192), .done(done192)
`ifdef AES_ENC_ROUND_TAP_EN
      , .round_state(rs192), .round_idx(ri192)
`endif
   );

   aes_encrypt_iter #(.Nk(8), .Nr(14)) dut256 (
      .clk(clk), .reset(reset), .start(start256), .in(din), .key(key256),
      .out(out256), .busy(busy256), .done(done256)
`ifdef AES_ENC_ROUND_TAP_EN
      , .round_state(rs256), .round_idx(ri256)
`endif
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Counts edges until the selected instance pulses done; -1 if the budget runs out.
   task automatic wait_done(input int which, input int limit, output int cyc);
      cyc = -1;
      for (int n = 1; n <= limit; n++) begin
         tick();
         if ((which == 0 && done128) || (which == 1 && done192) || (which == 2 && done256)) begin
            cyc = n;
            break;
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      tick();
      checks++; if (out128 !== 128'h0) begin errors++; $display("FAIL reset_out: got %h expected 0", out128); end
      checks++; if (busy128 !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy128); end
      checks++; if (done128 !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done128); end
      checks++; if (out256 !== 128'h0) begin errors++; $display("FAIL reset_out256: got %h expected 0", out256); end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_aes128();
      int cyc;
      int busy_bad;
      din = PT_C; key128 = K128_C; start128 = 1'b1;
      tick();
      start128 = 1'b0;
      cyc = -1; busy_bad = 0;
      for (int n = 1; n <= 40; n++) begin
         if (busy128 !== 1'b1) busy_bad++;
         tick();
         if (done128) begin cyc = n; break; end
      end
      checks++; if (cyc != 11) begin errors++; $display("FAIL aes128_latency: got %0d expected 11", cyc); end
      checks++; if (busy_bad != 0) begin errors++; $display("FAIL aes128_busy_window: got %0d low cycles expected 0", busy_bad); end
      checks++; if (out128 !== CT128) begin errors++; $display("FAIL aes128_out: got %h expected %h", out128, CT128); end
      checks++; if (busy128 !== 1'b0) begin errors++; $display("FAIL aes128_busy_at_done: got %b expected 0", busy128); end
      tick();
      checks++; if (done128 !== 1'b0) begin errors++; $display("FAIL aes128_done_width: got %b expected 0", done128); end
   endtask

   task automatic test_aes192_256();
      int cyc;
      din = PT_C; key192 = K192_C; start192 = 1'b1;
      tick();
      start192 = 1'b0;
      wait_done(1, 40, cyc);
      checks++; if (cyc != 13) begin errors++; $display("FAIL aes192_latency: got %0d expected 13", cyc); end
      checks++; if (out192 !== CT192) begin errors++; $display("FAIL aes192_out: got %h expected %h", out192, CT192); end
      key256 = K256_C; start256 = 1'b1;
      tick();
      start256 = 1'b0;
      wait_done(2, 40, cyc);
      checks++; if (cyc != 15) begin errors++; $display("FAIL aes256_latency: got %0d expected 15", cyc); end
      checks++; if (out256 !== CT256) begin errors++; $display("FAIL aes256_out: got %h expected %h", out256, CT256); end
   endtask

   task automatic test_input_stability();
      int ndone;
      int cyc;
      logic [127:0] r1;
      din = PT_B; key128 = K_B; start128 = 1'b1;
      tick();
      ndone = 0; cyc = -1; r1 = '0;
      for (int n = 1; n <= 20; n++) begin
         start128 = busy128;
         if (busy128) begin
            din    = {$urandom, $urandom, $urandom, $urandom};
            key128 = {$urandom, $urandom, $urandom, $urandom};
         end
         tick();
         if (done128) begin ndone++; cyc = n; end
`ifdef AES_ENC_ROUND_TAP_EN
         if (n == 2) r1 = rs128;
`endif
      end
      start128 = 1'b0;
      checks++; if (ndone != 1) begin errors++; $display("FAIL stab_done_count: got %0d expected 1", ndone); end
      checks++; if (cyc != 11) begin errors++; $display("FAIL stab_latency: got %0d expected 11", cyc); end
      checks++; if (out128 !== CT_B) begin errors++; $display("FAIL stab_out: got %h expected %h", out128, CT_B); end
`ifdef AES_ENC_ROUND_TAP_EN
      checks++; if (r1 !== R1_B) begin errors++; $display("FAIL stab_round1: got %h expected %h", r1, R1_B); end
`endif
   endtask

   task automatic test_back_to_back();
      int cyc1;
      int cyc2;
      din = PT_C; key128 = K128_C; start128 = 1'b1;
      tick();
      start128 = 1'b0;
      wait_done(0, 40, cyc1);
      checks++; if (cyc1 != 11) begin errors++; $display("FAIL b2b_first_latency: got %0d expected 11", cyc1); end
      checks++; if (out128 !== CT128) begin errors++; $display("FAIL b2b_first_out: got %h expected %h", out128, CT128); end
      din = PT_B; key128 = K_B; start128 = 1'b1;
      tick();
      start128 = 1'b0;
      wait_done(0, 40, cyc2);
      checks++; if (cyc2 + 1 != 12) begin errors++; $display("FAIL b2b_gap: got %0d expected 12", cyc2 + 1); end
      checks++; if (out128 !== CT_B) begin errors++; $display("FAIL b2b_second_out: got %h expected %h", out128, CT_B); end
   endtask

   task automatic test_reset_midop();
      int ndone;
      int cyc;
      din = PT_C; key128 = K128_C; start128 = 1'b1;
      tick();
      start128 = 1'b0;
      for (int n = 0; n < 4; n++) tick();
      reset = 1'b1;
      tick();
      checks++; if (out128 !== 128'h0) begin errors++; $display("FAIL midrst_out: got %h expected 0", out128); end
      checks++; if (busy128 !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", busy128); end
      checks++; if (done128 !== 1'b0) begin errors++; $display("FAIL midrst_done: got %b expected 0", done128); end
      reset = 1'b0;
      ndone = 0;
      for (int n = 0; n < 20; n++) begin
         tick();
         if (done128) ndone++;
      end
      checks++; if (ndone != 0) begin errors++; $display("FAIL midrst_no_done: got %0d pulses expected 0", ndone); end
      start128 = 1'b1;
      tick();
      start128 = 1'b0;
      wait_done(0, 40, cyc);
      checks++; if (cyc != 11) begin errors++; $display("FAIL midrst_restart_latency: got %0d expected 11", cyc); end
      checks++; if (out128 !== CT128) begin errors++; $display("FAIL midrst_restart_out: got %h expected %h", out128, CT128); end
   endtask

   task automatic test_idle_hold();
      int out_bad;
      int done_seen;
      int busy_seen;
      out_bad = 0; done_seen = 0; busy_seen = 0;
      for (int n = 0; n < 50; n++) begin
         tick();
         if (out128 !== CT128) out_bad++;
         if (done128 !== 1'b0) done_seen++;
         if (busy128 !== 1'b0) busy_seen++;
      end
      checks++; if (out_bad != 0) begin errors++; $display("FAIL idle_out_hold: got %0d changed cycles expected 0", out_bad); end
      checks++; if (done_seen != 0) begin errors++; $display("FAIL idle_done: got %0d high cycles expected 0", done_seen); end
      checks++; if (busy_seen != 0) begin errors++; $display("FAIL idle_busy: got %0d high cycles expected 0", busy_seen); end
   endtask

   initial begin
      reset = 1'b1;
      start128 = 1'b0; start192 = 1'b0; start256 = 1'b0;
      din = '0; key128 = '0; key192 = '0; key256 = '0;
      test_reset();
      test_aes128();
      test_aes192_256();
      test_input_stability();
      test_back_to_back();
      test_reset_midop();
      test_idle_hold();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
